// File: rtl/huff_pkg.sv
// Shared definitions for the Huffman symbol sorter and coder: FSM state
// encoding and count-ordering mode constants.
package huff_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_SCAN = 2'd1,
      S_EMIT = 2'd2,
      S_DONE = 2'd3
   } state_t;

   localparam logic MODE_DESC = 1'b0;
   localparam logic MODE_ASC  = 1'b1;

endpackage

// File: rtl/huff_cmp.sv
// Mode-dependent strict compare: take is high when cand should replace best.
// Strictness keeps the lowest index among equal counts.
module huff_cmp
   import huff_pkg::*;
#(
   parameter int CW = 8
) (
   input  logic [CW-1:0] cand,
   input  logic [CW-1:0] best,
   input  logic          best_valid,
   input  logic          mode,
   output logic          take
);

   // Candidate wins if no best yet, else by strict mode-dependent ordering
   always_comb begin
      take = 1'b0;
      if (!best_valid) begin
         take = 1'b1;
      end else begin
         case (mode)
            MODE_DESC: take = (cand > best);
            MODE_ASC:  take = (cand < best);
            default:   take = 1'b0;
         endcase
      end
   end

endmodule

// File: rtl/huff_sorter.sv
// Selection sorter for Huffman symbol counts: one symbol examined per SCAN
// cycle, one rank written per EMIT cycle, result held until the next start.
module huff_sorter
   import huff_pkg::*;
#(
   parameter int NSYM = 8,
   parameter int CW   = 8,
   parameter int IW   = $clog2(NSYM)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [IW:0]          num,
   input  logic                 mode,
   input  logic [NSYM*CW-1:0]   cnt_in,
   output logic                 busy,
   output logic                 done,
   output logic [NSYM*IW-1:0]   order
);

   localparam logic [IW:0] NSYM_L = (IW+1)'(NSYM);
   localparam logic [IW:0] ONE_L  = (IW+1)'(1);

   state_t            state_r;
   logic              busy_r;
   logic              done_r;
   logic [CW-1:0]     cnt_r [NSYM];
   logic              mode_r;
   logic [IW:0]       num_r;
   logic [NSYM-1:0]   taken_r;
   logic [IW:0]       j_r;
   logic [IW:0]       k_r;
   logic [CW-1:0]     best_r;
   logic [IW-1:0]     best_idx_r;
   logic              best_valid_r;
   logic [IW-1:0]     order_r [NSYM];

   logic [IW:0]       num_clamp_s;
   logic [IW-1:0]     j_idx_s;
   logic              take_s;

   assign num_clamp_s = (num > NSYM_L) ? NSYM_L : num;
   assign j_idx_s     = j_r[IW-1:0];

   huff_cmp #(.CW(CW)) u_cmp (
      .cand       (cnt_r[j_idx_s]),
      .best       (best_r),
      .best_valid (best_valid_r),
      .mode       (mode_r),
      .take       (take_s)
   );

   // Sorter FSM with captured operands and registered status/result
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r      <= S_IDLE;
         busy_r       <= 1'b0;
         done_r       <= 1'b0;
         mode_r       <= MODE_DESC;
         num_r        <= {(IW+1){1'b0}};
         taken_r      <= {NSYM{1'b0}};
         j_r          <= {(IW+1){1'b0}};
         k_r          <= {(IW+1){1'b0}};
         best_r       <= {CW{1'b0}};
         best_idx_r   <= {IW{1'b0}};
         best_valid_r <= 1'b0;
         for (int i = 0; i < NSYM; i++) begin
            cnt_r[i]   <= {CW{1'b0}};
            order_r[i] <= {IW{1'b0}};
         end
      end else begin
         case (state_r)
            S_IDLE, S_DONE: begin
               // done rises one cycle after the FSM settles in DONE
               if (state_r == S_DONE) begin
                  done_r <= 1'b1;
               end
               if (start) begin
                  done_r       <= 1'b0;
                  mode_r       <= mode;
                  num_r        <= num_clamp_s;
                  taken_r      <= {NSYM{1'b0}};
                  j_r          <= {(IW+1){1'b0}};
                  k_r          <= {(IW+1){1'b0}};
                  best_r       <= {CW{1'b0}};
                  best_idx_r   <= {IW{1'b0}};
                  best_valid_r <= 1'b0;
                  for (int i = 0; i < NSYM; i++) begin
                     cnt_r[i]   <= cnt_in[i*CW +: CW];
                     order_r[i] <= {IW{1'b0}};
                  end
                  if (num_clamp_s == {(IW+1){1'b0}}) begin
                     state_r <= S_DONE;
                     busy_r  <= 1'b0;
                  end else begin
                     state_r <= S_SCAN;
                     busy_r  <= 1'b1;
                  end
               end
            end
            S_SCAN: begin
               if (!taken_r[j_idx_s] && take_s) begin
                  best_r       <= cnt_r[j_idx_s];
                  best_idx_r   <= j_idx_s;
                  best_valid_r <= 1'b1;
               end
               if (j_r == num_r - ONE_L) begin
                  j_r     <= {(IW+1){1'b0}};
                  state_r <= S_EMIT;
               end else begin
                  j_r <= j_r + ONE_L;
               end
            end
            S_EMIT: begin
               order_r[k_r[IW-1:0]] <= best_idx_r;
               taken_r[best_idx_r]  <= 1'b1;
               best_r               <= {CW{1'b0}};
               best_idx_r           <= {IW{1'b0}};
               best_valid_r         <= 1'b0;
               k_r                  <= k_r + ONE_L;
               if (k_r == num_r - ONE_L) begin
                  state_r <= S_DONE;
                  busy_r  <= 1'b0;
               end else begin
                  state_r <= S_SCAN;
               end
            end
            default: begin
               state_r <= S_IDLE;
               busy_r  <= 1'b0;
               done_r  <= 1'b0;
            end
         endcase
      end
   end

   assign busy = busy_r;
   assign done = done_r;

   for (genvar g = 0; g < NSYM; g++) begin : g_order
      assign order[g*IW +: IW] = order_r[g];
   end

endmodule

// File: tb/tb_huff_sorter.sv
// Self-checking bench for huff_sorter: directed cases plus randomized sorts
// compared against a rank-counting reference model.
module tb_huff_sorter;

   localparam int NSYM = 8;
   localparam int CW   = 8;
   localparam int IW   = $clog2(NSYM);

   logic                 clk;
   logic                 reset;
   logic                 start;
   logic [IW:0]          num;
   logic                 mode;
   logic [NSYM*CW-1:0]   cnt_in;
   logic                 busy;
   logic                 done;
   logic [NSYM*IW-1:0]   order;

   int n_checks = 0;
   int n_errors = 0;

   huff_sorter #(.NSYM(NSYM), .CW(CW)) dut (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .num    (num),
      .mode   (mode),
      .cnt_in (cnt_in),
      .busy   (busy),
      .done   (done),
      .order  (order)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Rank of symbol i = number of active symbols that must precede it
   task automatic model(input int ne, input logic m, input logic [NSYM*CW-1:0] cv,
                        output logic [NSYM*IW-1:0] op);
      int c [NSYM];
      int r;
      op = '0;
      for (int i = 0; i < NSYM; i++) c[i] = int'(cv[i*CW +: CW]);
      for (int i = 0; i < ne; i++) begin
         r = 0;
         for (int j = 0; j < ne; j++) begin
            if ((m ? (c[j] < c[i]) : (c[j] > c[i])) || (c[j] == c[i] && j < i)) r++;
         end
         op[r*IW +: IW] = IW'(i);
      end
   endtask

   task automatic run_sort(input int n, input logic m, input logic [NSYM*CW-1:0] cv,
                           input bit disturb, input string tag,
                           output logic [NSYM*IW-1:0] exp_pack);
      int ne;
      int cyc;
      ne = (n > NSYM) ? NSYM : n;
      model(ne, m, cv, exp_pack);
      @(negedge clk);
      num = (IW+1)'(n); mode = m; cnt_in = cv; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      check({tag, "_busy"}, 64'(busy), 64'(ne > 0));
      check({tag, "_done_lo"}, 64'(done), 64'(0));
      cyc = 0;
      while (!done && cyc < 200) begin
         @(posedge clk);
         cyc++;
         #1;
         if (disturb && cyc == 5) begin
            start = 1'b1; cnt_in = {$urandom, $urandom}; mode = ~m; num = (IW+1)'(2);
         end else begin
            start = 1'b0;
         end
      end
      start = 1'b0;
      check({tag, "_latency"}, 64'(cyc), 64'(ne * (ne + 1) + 1));
      check({tag, "_order"}, 64'(order), 64'(exp_pack));
      repeat (3) @(posedge clk);
      #1;
      check({tag, "_hold_done"}, 64'(done), 64'(1));
      check({tag, "_hold_busy"}, 64'(busy), 64'(0));
      check({tag, "_hold_order"}, 64'(order), 64'(exp_pack));
   endtask

   function automatic logic [NSYM*CW-1:0] pack6(input int a, b, c, d, e, f);
      logic [NSYM*CW-1:0] v;
      v = '0;
      v[0*CW +: CW] = CW'(a); v[1*CW +: CW] = CW'(b); v[2*CW +: CW] = CW'(c);
      v[3*CW +: CW] = CW'(d); v[4*CW +: CW] = CW'(e); v[5*CW +: CW] = CW'(f);
      return v;
   endfunction

   initial begin
      logic [NSYM*IW-1:0] ep;
      logic [NSYM*CW-1:0] cv;
      logic [NSYM*IW-1:0] lit;
      int rn;
      reset = 1'b1; start = 1'b0; num = '0; mode = 1'b0; cnt_in = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_busy", 64'(busy), 64'(0));
      check("rst_done", 64'(done), 64'(0));
      check("rst_order", 64'(order), 64'(0));
      @(negedge clk) reset = 1'b0;

      cv = pack6(12, 7, 3, 25, 7, 1);
      run_sort(6, 1'b0, cv, 1'b0, "desc6", ep);
      lit = {3'd0, 3'd0, 3'd5, 3'd2, 3'd4, 3'd1, 3'd0, 3'd3};
      check("desc6_const", 64'(order), 64'(lit));
      run_sort(6, 1'b1, cv, 1'b0, "asc6", ep);
      lit = {3'd0, 3'd0, 3'd3, 3'd0, 3'd4, 3'd1, 3'd2, 3'd5};
      check("asc6_const", 64'(order), 64'(lit));

      cv = '0;
      for (int i = 0; i < NSYM; i++) cv[i*CW +: CW] = CW'(9);
      run_sort(4, 1'b0, cv, 1'b0, "ties4", ep);
      lit = {3'd0, 3'd0, 3'd0, 3'd0, 3'd3, 3'd2, 3'd1, 3'd0};
      check("ties4_const", 64'(order), 64'(lit));

      run_sort(0, 1'b0, pack6(4, 5, 6, 7, 8, 9), 1'b0, "num0", ep);
      run_sort(1, 1'b1, pack6(4, 5, 6, 7, 8, 9), 1'b0, "num1", ep);

      // Abandon a sort during the third rank's scan
      @(negedge clk);
      num = (IW+1)'(6); mode = 1'b0; cnt_in = pack6(12, 7, 3, 25, 7, 1); start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (16) @(posedge clk);
      #1 reset = 1'b1;
      #1;
      check("midrst_busy", 64'(busy), 64'(0));
      check("midrst_done", 64'(done), 64'(0));
      check("midrst_order", 64'(order), 64'(0));
      @(negedge clk) reset = 1'b0;
      cv = {$urandom, $urandom};
      cv[0 +: 3*CW] = {CW'(0), CW'(5), CW'(0)};
      run_sort(3, 1'b0, cv, 1'b0, "after_rst", ep);
      lit = {3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd2, 3'd0, 3'd1};
      check("after_rst_const", 64'(order), 64'(lit));

      run_sort(6, 1'b0, pack6(12, 7, 3, 25, 7, 1), 1'b1, "disturb", ep);
      lit = {3'd0, 3'd0, 3'd5, 3'd2, 3'd4, 3'd1, 3'd0, 3'd3};
      check("disturb_const", 64'(order), 64'(lit));

      for (int t = 0; t < 24; t++) begin
         cv = {$urandom, $urandom};
         if (t % 2 == 0) begin
            for (int i = 0; i < NSYM; i++) cv[i*CW +: CW] = CW'($urandom_range(0, 3));
         end
         rn = $urandom_range(0, 10);
         run_sort(rn, 1'($urandom_range(0, 1)), cv, (rn >= 3) && (t % 3 == 0), "rand", ep);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/huff_sorter.md
HUFF_SORTER -- requirements
Module: huff_sorter

Interface
REQ-001 SHALL provide parameter NSYM, default 8, maximum number of symbols to sort.
REQ-002 SHALL provide parameter CW, default 8, bit width of each symbol count.
REQ-003 SHALL provide derived parameter IW, default $clog2(NSYM), bit width of a symbol index.
REQ-004 SHALL provide port clk  input  1  clock; all state updates on rising edge.
REQ-005 SHALL provide port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL provide port start  input  1  request to sort; sampled only in IDLE or DONE.
REQ-007 SHALL provide port num  input  IW+1  number of active symbols, entries 0..num-1.
REQ-008 SHALL provide port mode  input  1  0 = descending counts, 1 = ascending counts.
REQ-009 SHALL provide port cnt_in  input  NSYM*CW  packed counts, symbol i at bits [i*CW +: CW].
REQ-010 SHALL provide port busy  output  1  high while in SCAN or EMIT.
REQ-011 SHALL provide port done  output  1  high while in DONE.
REQ-012 SHALL provide port order  output  NSYM*IW  rank k holds symbol index at bits [k*IW +: IW].

Function
REQ-013 SHALL implement FSM states IDLE, SCAN, EMIT, DONE.
REQ-014 On start in IDLE or DONE: SHALL capture cnt_in, mode and clamped num (num>NSYM treated as NSYM); clear taken mask, rank k, order; next state SCAN.
REQ-015 Captured inputs SHALL be held; later changes on cnt_in/num/mode SHALL NOT affect the current sort.
REQ-016 SCAN SHALL examine one symbol j per cycle, j = 0..num-1, skipping taken symbols; SHALL track best untaken count and its index.
REQ-017 Best update SHALL use strict comparison (> for mode 0, < for mode 1), so ties resolve to the lower index (stable).
REQ-018 Zero counts SHALL be valid entries; exclusion SHALL rely only on the taken mask.
REQ-019 After j = num-1, next state SHALL be EMIT; EMIT SHALL write best index to order rank k, set its taken bit, increment k and clear best.
REQ-020 EMIT SHALL go to DONE when k reaches num-1 (last rank written), otherwise back to SCAN with j = 0.
REQ-021 With start sampled at edge T, done SHALL first be high at T + num*(num+1) + 1 cycles.
REQ-022 num = 0 SHALL go from start directly to DONE in one cycle with order all zero.
REQ-023 Ranks k >= num in order SHALL read 0.
REQ-024 start while busy SHALL be ignored.
REQ-025 done SHALL stay high and order SHALL stay stable until the next accepted start.

Reset
REQ-026 reset SHALL force IDLE; busy = 0, done = 0, order = 0; clear taken mask, k, j, best and captured registers.
REQ-027 reset asserted mid-sort SHALL abandon the sort; no partial order SHALL remain visible after release.

Structure
REQ-028 Package huff_pkg SHALL hold the FSM state enum and the MODE_DESC/MODE_ASC constants shared with the Huffman coder.
REQ-029 Sub-module huff_cmp SHALL implement the mode-dependent strict compare (inputs cand, best, best_valid, mode; output take).

Verification
REQ-030 num=6, counts {12,7,3,25,7,1}, mode 0 -> order ranks 0..5 = 3,0,1,4,2,5; done at T+43.
REQ-031 Same counts, mode 1 -> order = 5,2,1,4,0,3.
REQ-032 num=4, counts all 9 -> order = 0,1,2,3 (stable ties); ranks 4..7 = 0.
REQ-033 num=0 -> done at T+1, order all zero; num=1 -> order rank 0 = 0, done at T+3.
REQ-034 Reset asserted during SCAN of rank 2, then start with num=3, counts {0,5,0} -> order = 1,0,2; no stale ranks.
REQ-035 start pulsed while busy and cnt_in changed mid-sort -> result matches the original captured inputs, latency unchanged.
